// File: rtl/neg_chunked.sv
// Chunk-serial conditional two's-complement negator: pass / negate / abs / nabs.
// One WIDTH-bit word is processed CHUNK bits per cycle, LSB chunk first, with a rippled carry.
module neg_chunked #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned N = WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  logic             neg_acc;
  logic [CHUNK-1:0] chunk_in;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_ext;

  always_comb begin
    unique case (mode)
      2'b00:   neg_acc = 1'b0;
      2'b01:   neg_acc = 1'b1;
      2'b10:   neg_acc = in_data[WIDTH-1];
      default: neg_acc = ~in_data[WIDTH-1] && (in_data != '0);
    endcase
  end

  // Operand shifts right each RUN cycle, so the current chunk is always in the low bits.
  always_comb begin
    chunk_in = neg_q ? ~src_q[CHUNK-1:0] : src_q[CHUNK-1:0];
    sum      = {1'b0, chunk_in} + {{CHUNK{1'b0}}, carry_q};
    res_ext  = '0;
    res_ext[CHUNK-1:0] = sum[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    res_d   = res_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          src_d   = in_data;
          neg_d   = neg_acc;
          carry_d = neg_acc;
          ovf_d   = neg_acc && (in_data == MinVal);
          idx_d   = '0;
        end
      end
      StRun: begin
        // Result enters at the top; after N shifts chunk 0 lands in the low bits.
        src_d   = src_q >> CHUNK;
        res_d   = (res_q >> CHUNK) | (res_ext << (WIDTH - CHUNK));
        carry_d = sum[CHUNK];
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = res_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_neg_chunked.sv
// Scoreboard bench for neg_chunked at CHUNK = 1, 4 and 16 (WIDTH = 16).
module tb_neg_chunked;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_data   [3];
  logic [1:0]  mode      [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_data  [3];
  logic        out_ovf   [3];
  logic        busy      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Ck = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    neg_chunked #(.WIDTH(16), .CHUNK(Ck)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .mode      (mode[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_ovf   (out_ovf[g]),
      .busy      (busy[g])
    );
  end

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          sel = 1;
  int          acc_cyc = 0;
  bit          acc_pend = 1'b0;
  logic [16:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] d, input logic [1:0] m);
    logic n;
    case (m)
      2'b00:   n = 1'b0;
      2'b01:   n = 1'b1;
      2'b10:   n = d[15];
      default: n = !d[15] && (d != 16'h0000);
    endcase
    return {n && (d == 16'h8000), n ? 16'(~d + 16'd1) : d};
  endfunction

  function automatic int nchunk(input int s);
    return (s == 0) ? 16 : (s == 1) ? 4 : 1;
  endfunction

  // Monitor: latency from accept to out_valid, and scoreboard pop on output handshake.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      exp_q.delete();
      acc_pend = 1'b0;
    end else begin
      if (in_valid[sel] && in_ready[sel]) begin
        acc_pend = 1'b1;
        acc_cyc  = cyc + 1;
      end
      if (out_valid[sel] && acc_pend) begin
        check("latency", 32'(cyc - acc_cyc), 32'(nchunk(sel)));
        acc_pend = 1'b0;
      end
      if (out_valid[sel] && out_ready[sel]) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(out_valid[sel]), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data[sel]), 32'(e[15:0]));
          check("out_ovf", 32'(out_ovf[sel]), 32'(e[16]));
        end
      end
    end
  end

  task automatic send(input int s, input logic [15:0] d, input logic [1:0] m, input bit rnd);
    int guard = 0;
    while (!in_ready[s] && guard < 200) begin
      if (rnd) out_ready[s] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready[s]) check("accept_timeout", 32'(in_ready[s]), 32'd1);
    in_valid[s] = 1'b1;
    in_data[s]  = d;
    mode[s]     = m;
    exp_q.push_back(model(d, m));
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    in_data[s]  = 16'($urandom);
    mode[s]     = 2'($urandom_range(0, 3));
    if (rnd) out_ready[s] = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int s);
    int guard = 0;
    out_ready[s] = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [15:0] sp [4] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};

  initial begin
    logic [15:0] d;
    logic [1:0]  m;
    int          guard;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; mode[i] = '0; out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check("rst_out_data", 32'(out_data[i]), 32'd0);
      check("rst_out_ovf", 32'(out_ovf[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_in_ready", 32'(in_ready[i]), 32'd1);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases on CHUNK=4.
    sel = 1;
    send(1, 16'h0005, 2'b01, 1'b0); drain(1);
    send(1, 16'hFFF0, 2'b10, 1'b0); drain(1);
    send(1, 16'h0010, 2'b10, 1'b0); drain(1);
    send(1, 16'h0010, 2'b11, 1'b0); drain(1);
    send(1, 16'h0000, 2'b11, 1'b0); drain(1);
    send(1, 16'h8000, 2'b01, 1'b0); drain(1);
    send(1, 16'h0000, 2'b01, 1'b0); drain(1);
    send(1, 16'h8000, 2'b00, 1'b0); drain(1);
    send(1, 16'h8000, 2'b10, 1'b0); drain(1);

    // Backpressure in DONE.
    out_ready[1] = 1'b0;
    send(1, 16'h8000, 2'b01, 1'b0);
    guard = 0;
    while (!out_valid[1] && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!out_valid[1]) check("done_timeout", 32'(out_valid[1]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1'b1; in_data[1] = 16'h0001; mode[1] = 2'b01;
      @(negedge clk);
      check("hold_data", 32'(out_data[1]), 32'h8000);
      check("hold_ovf", 32'(out_ovf[1]), 32'd1);
      check("hold_in_ready", 32'(in_ready[1]), 32'd0);
      check("hold_out_valid", 32'(out_valid[1]), 32'd1);
      @(posedge clk);
      #1;
      in_valid[1] = 1'b0;
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 32'(out_valid[1]), 32'd0);
    check("release_in_ready", 32'(in_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    check("release_busy", 32'(busy[1]), 32'd0);

    // Reset while chunk 2 is in progress.
    send(1, 16'hABCD, 2'b01, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("run_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid[1]), 32'd0);
    check("arst_busy", 32'(busy[1]), 32'd0);
    check("arst_in_ready", 32'(in_ready[1]), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1, 16'h1234, 2'b01, 1'b0); drain(1);

    // Random sweep with random backpressure on each chunk size.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 1000; k++) begin
        d = ($urandom_range(0, 7) == 0) ? sp[$urandom_range(0, 3)] : 16'($urandom);
        m = 2'($urandom_range(0, 3));
        send(s, d, m, 1'b1);
      end
      drain(s);
      @(posedge clk);
      #1;
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
